// File: rtl/uart_out_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_out_arbiter_pkg
// Description : Shared constants, types and helpers for the UART output
//               arbiter: message width, requester port indices and slot state.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_out_arbiter_pkg;

    // Width of one UART message word handed to the disassembler FIFO
    localparam int UART_MSG_WIDTH = 8;

    // Requester port indices
    localparam int UART_ARB_PORT_CTRL   = 0;
    localparam int UART_ARB_PORT_MEM    = 1;
    localparam int UART_ARB_PORT_STATUS = 2;

    // Output slot occupancy
    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Round-robin pointer successor over ports 1..num_req-1 (port 0 excluded)
    function automatic int rr_next_ptr(input int k, input int num_req);
        return (k + 1 >= num_req) ? 1 : k + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_out_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_out_arbiter_if
// Description : Request / FIFO-side bundle of the UART output arbiter.
//               master : message sources + FIFO status (drives requests, full)
//               slave  : the arbiter (drives acks, FIFO data/strobe, status)
//   req_valid [NUM_REQ]           per-port request, held until acked
//   req_msg   [NUM_REQ*MSG_WIDTH] port i in [i*MSG_WIDTH +: MSG_WIDTH]
//   req_ack   [NUM_REQ]           one-hot capture pulse
//   fifo_full                     disassembler FIFO full
//   fifo_msg  [MSG_WIDTH]         FIFO write data
//   fifo_wr_en                    FIFO write strobe
//   grant_id  [$clog2(NUM_REQ)]   source port of the held message
//   busy                          slot occupied
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_out_arbiter_if
    import uart_out_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MSG_WIDTH = UART_MSG_WIDTH
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*MSG_WIDTH-1:0] req_msg;
    logic [NUM_REQ-1:0]           req_ack;
    logic                         fifo_full;
    logic [MSG_WIDTH-1:0]         fifo_msg;
    logic                         fifo_wr_en;
    logic [ID_W-1:0]              grant_id;
    logic                         busy;

    modport master (
        output req_valid, req_msg, fifo_full,
        input  req_ack, fifo_msg, fifo_wr_en, grant_id, busy
    );

    modport slave (
        input  req_valid, req_msg, fifo_full,
        output req_ack, fifo_msg, fifo_wr_en, grant_id, busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_out_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_out_arbiter_rr_arbiter
// Description : Combinational round-robin selector. Picks the first set bit
//               of valid at or above ptr, wrapping to the lowest set bit.
//   valid [NUM_REQ] candidate mask
//   ptr   [ID_W]    search start position
//   grant [NUM_REQ] one-hot winner (zero when valid is empty)
//   idx   [ID_W]    winner index (zero when valid is empty)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_out_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_sel;

    always_comb begin
        w_hi  = '0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_hi[i] = valid[i] && (i >= int'(ptr));
        end
        // Prefer candidates at/after the pointer; otherwise wrap to the bottom
        w_sel = (|w_hi) ? w_hi : valid;
        // Descending scan leaves the lowest set bit as the winner
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                idx = i[ID_W-1:0];
            end
        end
        if (|w_sel) begin
            grant[idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_out_arbiter
// Description : Shares the UART transmit FIFO between NUM_REQ message sources.
//               Port 0 has priority bounded to PRIO_BURST consecutive grants
//               while others wait; ports 1..NUM_REQ-1 are round-robin. One
//               registered message slot, never written into a full FIFO.
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    uart_out_arbiter_if.slave (requests, acks, FIFO side, status)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_out_arbiter
    import uart_out_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int MSG_WIDTH  = UART_MSG_WIDTH,
    parameter int PRIO_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    uart_out_arbiter_if.slave  bus
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int BURST_W = $clog2(PRIO_BURST + 1);

    slot_state_t            r_state;
    logic [MSG_WIDTH-1:0]   r_msg;
    logic [ID_W-1:0]        r_grant_id;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [BURST_W-1:0]     r_burst;

    logic                   w_busy;
    logic                   w_wr_en;
    logic                   w_cap_ok;
    logic                   w_others;
    logic                   w_p0_win;
    logic                   w_capture;
    logic [NUM_REQ-1:0]     w_rr_valid;
    logic [NUM_REQ-1:0]     w_rr_grant;
    logic [ID_W-1:0]        w_rr_idx;
    logic [ID_W-1:0]        w_win_idx;
    logic [MSG_WIDTH-1:0]   w_win_msg;

    // Port 0 is masked out so the round-robin only ever sees ports 1..N-1
    assign w_rr_valid = {bus.req_valid[NUM_REQ-1:1], 1'b0};

    uart_out_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .valid (w_rr_valid),
        .ptr   (r_rr_ptr),
        .grant (w_rr_grant),
        .idx   (w_rr_idx)
    );

    assign w_busy    = (r_state == SLOT_FULL);
    assign w_wr_en   = w_busy & ~bus.fifo_full;
    // A draining slot can be refilled in the same cycle
    assign w_cap_ok  = ~w_busy | w_wr_en;
    assign w_others  = |bus.req_valid[NUM_REQ-1:1];
    assign w_p0_win  = bus.req_valid[0] & ((int'(r_burst) < PRIO_BURST) | ~w_others);
    // Acks are suppressed while reset is held so outputs are quiet immediately
    assign w_capture = ~reset & w_cap_ok & (|bus.req_valid);
    assign w_win_idx = w_p0_win ? '0 : w_rr_idx;
    assign w_win_msg = bus.req_msg[int'(w_win_idx)*MSG_WIDTH +: MSG_WIDTH];

    assign bus.req_ack    = w_capture ? (w_p0_win ? NUM_REQ'(1) : w_rr_grant) : '0;
    assign bus.fifo_wr_en = w_wr_en;
    assign bus.fifo_msg   = r_msg;
    assign bus.grant_id   = r_grant_id;
    assign bus.busy       = w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= SLOT_EMPTY;
            r_msg      <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= ID_W'(1);
            r_burst    <= '0;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (w_capture) begin
                        r_state <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (w_wr_en && !w_capture) begin
                        r_state <= SLOT_EMPTY;
                    end
                end
                default: r_state <= SLOT_EMPTY;
            endcase

            if (w_capture) begin
                r_msg      <= w_win_msg;
                r_grant_id <= w_win_idx;
            end

            if (w_capture && !w_p0_win) begin
                r_rr_ptr <= ID_W'(rr_next_ptr(int'(w_rr_idx), NUM_REQ));
            end

            // The burst limit only matters while someone else is waiting
            if (!w_others) begin
                r_burst <= '0;
            end else if (w_capture) begin
                if (w_p0_win) begin
                    if (int'(r_burst) < PRIO_BURST) begin
                        r_burst <= r_burst + BURST_W'(1);
                    end
                end else begin
                    r_burst <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
